// File: rtl/park_pkg.sv
// Shared encodings for the parking-lot controller: FSM states, timer width
// and the seven-segment code shown when the lot is full.
package park_pkg;

   localparam int TIMER_W = 8;

   localparam logic [3:0] SEV_FULL = 4'hF;

   typedef enum logic [1:0] {
      E_IDLE   = 2'd0,
      E_TICKET = 2'd1,
      E_FULL   = 2'd2,
      E_OPEN   = 2'd3
   } entry_state_t;

   typedef enum logic [1:0] {
      X_IDLE = 2'd0,
      X_PAY  = 2'd1,
      X_OPEN = 2'd2
   } exit_state_t;

endpackage

// File: rtl/park_gate_timer.sv
// 8-bit loadable down-counter. done is raised on the last counted cycle so
// the owning FSM can leave its state on the edge that ends the interval.
module park_gate_timer
   import park_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   output logic               done
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   // A value of N loaded on entry keeps the state for exactly N cycles.
   assign done = (count <= TIMER_W'(1));

endmodule

// File: rtl/park_lot_ctrl.sv
// Parking-lot controller: independent entry and exit gate FSMs sharing a
// registered occupancy counter, with full indicator and seven-segment code.
module park_lot_ctrl
   import park_pkg::*;
#(
   parameter  int CAPACITY         = 5,
   parameter  int GATE_OPEN_CYCLES = 4,
   parameter  int TICKET_TIMEOUT   = 16,
   localparam int CNT_W            = $clog2(CAPACITY + 1)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             Ent_Sens,
   input  logic             Exit_Sens,
   input  logic             Tick_1,
   input  logic             paid_stat,
   output logic             Ent_Gate,
   output logic             Green_State,
   output logic             Red_State,
   output logic [3:0]       Sev_indicator,
   output logic [CNT_W-1:0] free_spots,
   output logic             timeout_pulse
);

   localparam logic [CNT_W-1:0]   CAP_C     = CNT_W'(CAPACITY);
   localparam logic [TIMER_W-1:0] GATE_C    = TIMER_W'(GATE_OPEN_CYCLES);
   localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMER_W'(TICKET_TIMEOUT);

   entry_state_t       ent_state, ent_next;
   exit_state_t        exit_state, exit_next;
   logic [CNT_W-1:0]   occ;
   logic               ent_load, exit_load;
   logic [TIMER_W-1:0] ent_load_val;
   logic               ent_done, exit_done;
   logic               ent_commit, exit_commit, ent_timeout;

   park_gate_timer u_ent_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (ent_load),
      .load_val (ent_load_val),
      .done     (ent_done)
   );

   park_gate_timer u_exit_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (exit_load),
      .load_val (GATE_C),
      .done     (exit_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_state     <= E_IDLE;
         exit_state    <= X_IDLE;
         timeout_pulse <= 1'b0;
      end else begin
         ent_state     <= ent_next;
         exit_state    <= exit_next;
         timeout_pulse <= ent_timeout;
      end
   end

   // The entry timer serves two purposes: ticket window, then gate hold.
   always_comb begin
      ent_next     = ent_state;
      ent_load     = 1'b0;
      ent_load_val = '0;
      ent_commit   = 1'b0;
      ent_timeout  = 1'b0;
      case (ent_state)
         E_IDLE: begin
            if (Ent_Sens) begin
               if (free_spots != '0) begin
                  ent_next     = E_TICKET;
                  ent_load     = 1'b1;
                  ent_load_val = TIMEOUT_C;
               end else begin
                  ent_next = E_FULL;
               end
            end
         end
         E_TICKET: begin
            if (Tick_1) begin
               ent_next     = E_OPEN;
               ent_load     = 1'b1;
               ent_load_val = GATE_C;
               ent_commit   = 1'b1;
            end else if (ent_done) begin
               ent_next    = E_IDLE;
               ent_timeout = 1'b1;
            end
         end
         E_FULL: begin
            if (!Ent_Sens) ent_next = E_IDLE;
         end
         E_OPEN: begin
            if (ent_done) ent_next = E_IDLE;
         end
         default: ent_next = E_IDLE;
      endcase
   end

   always_comb begin
      exit_next   = exit_state;
      exit_load   = 1'b0;
      exit_commit = 1'b0;
      case (exit_state)
         X_IDLE: begin
            if (Exit_Sens && (occ != '0)) exit_next = X_PAY;
         end
         X_PAY: begin
            if (paid_stat) begin
               exit_next   = X_OPEN;
               exit_load   = 1'b1;
               exit_commit = 1'b1;
            end
         end
         X_OPEN: begin
            if (exit_done) exit_next = X_IDLE;
         end
         default: exit_next = X_IDLE;
      endcase
   end

   // Simultaneous admit and release cancel out; the bounds guard is defensive.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ <= '0;
      end else begin
         case ({ent_commit, exit_commit})
            2'b10: if (occ != CAP_C) occ <= occ + 1'b1;
            2'b01: if (occ != '0)    occ <= occ - 1'b1;
            default: ;
         endcase
      end
   end

   assign free_spots    = CAP_C - occ;
   assign Red_State     = (free_spots == '0);
   assign Sev_indicator = (free_spots == '0) ? SEV_FULL : 4'(free_spots);
   assign Ent_Gate      = (ent_state == E_OPEN);
   assign Green_State   = (exit_state == X_OPEN);

endmodule

// File: tb/tb_park_lot_ctrl.sv
// Directed self-checking bench for park_lot_ctrl at CAPACITY=5,
// GATE_OPEN_CYCLES=4, TICKET_TIMEOUT=16.
module tb_park_lot_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       Ent_Sens, Exit_Sens, Tick_1, paid_stat;
   logic       Ent_Gate, Green_State, Red_State, timeout_pulse;
   logic [3:0] Sev_indicator;
   logic [2:0] free_spots;

   int n_checks = 0;
   int n_fail   = 0;

   park_lot_ctrl #(
      .CAPACITY         (5),
      .GATE_OPEN_CYCLES (4),
      .TICKET_TIMEOUT   (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .Ent_Sens      (Ent_Sens),
      .Exit_Sens     (Exit_Sens),
      .Tick_1        (Tick_1),
      .paid_stat     (paid_stat),
      .Ent_Gate      (Ent_Gate),
      .Green_State   (Green_State),
      .Red_State     (Red_State),
      .Sev_indicator (Sev_indicator),
      .free_spots    (free_spots),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic count_gates(output int ent_hi, output int exit_hi);
      ent_hi  = 0;
      exit_hi = 0;
      for (int j = 0; j < 12; j++) begin
         if (Ent_Gate)    ent_hi++;
         if (Green_State) exit_hi++;
         tick();
      end
   endtask

   task automatic do_entry(input int exp_free);
      int eh, xh;
      Ent_Sens = 1'b1;
      tick();
      Ent_Sens = 1'b0;
      Tick_1   = 1'b1;
      tick();
      Tick_1   = 1'b0;
      check("entry_free", free_spots, exp_free);
      count_gates(eh, xh);
      check("entry_gate_cycles", eh, 4);
   endtask

   task automatic do_exit(input int exp_free);
      int eh, xh;
      Exit_Sens = 1'b1;
      tick();
      Exit_Sens = 1'b0;
      paid_stat = 1'b1;
      tick();
      paid_stat = 1'b0;
      check("exit_free", free_spots, exp_free);
      count_gates(eh, xh);
      check("exit_gate_cycles", xh, 4);
   endtask

   initial begin
      int eh, xh, at, pulses, gate_seen;
      reset = 1'b0;
      Ent_Sens = 1'b0; Exit_Sens = 1'b0; Tick_1 = 1'b0; paid_stat = 1'b0;
      tick();
      tick();
      check("rst_ent_gate", Ent_Gate, 0);
      check("rst_green", Green_State, 0);
      check("rst_timeout", timeout_pulse, 0);
      reset = 1'b1;
      tick();
      check("post_rst_free", free_spots, 5);
      check("post_rst_sev", Sev_indicator, 5);
      check("post_rst_red", Red_State, 0);

      // Fill the lot
      for (int i = 0; i < 5; i++) do_entry(4 - i);
      check("full_sev", Sev_indicator, 15);
      check("full_red", Red_State, 1);

      // Sixth vehicle is refused, even if a ticket pulse appears
      Ent_Sens = 1'b1;
      tick();
      check("full_no_gate", Ent_Gate, 0);
      Tick_1 = 1'b1;
      tick();
      Tick_1 = 1'b0;
      tick();
      check("full_no_gate2", Ent_Gate, 0);
      check("full_free", free_spots, 0);
      Ent_Sens = 1'b0;
      tick();

      do_exit(1);
      check("one_free_sev", Sev_indicator, 1);
      check("one_free_red", Red_State, 0);
      do_exit(2);

      // Simultaneous entry and exit commits at occ=3
      Ent_Sens = 1'b1; Exit_Sens = 1'b1;
      tick();
      Ent_Sens = 1'b0; Exit_Sens = 1'b0;
      Tick_1 = 1'b1; paid_stat = 1'b1;
      tick();
      Tick_1 = 1'b0; paid_stat = 1'b0;
      check("simul_free", free_spots, 2);
      count_gates(eh, xh);
      check("simul_ent_cycles", eh, 4);
      check("simul_exit_cycles", xh, 4);

      // Ticket timeout
      Ent_Sens = 1'b1;
      tick();
      Ent_Sens = 1'b0;
      check("to_not_early", timeout_pulse, 0);
      at = -1; pulses = 0; gate_seen = 0;
      for (int j = 1; j <= 30; j++) begin
         tick();
         if (timeout_pulse) begin
            pulses++;
            if (at < 0) at = j;
         end
         if (Ent_Gate) gate_seen++;
      end
      check("to_cycle", at, 16);
      check("to_pulse_width", pulses, 1);
      check("to_no_gate", gate_seen, 0);
      check("to_free", free_spots, 2);

      do_entry(1);
      do_exit(2);
      do_exit(3);

      // Reset while waiting for payment at occ=2
      Exit_Sens = 1'b1;
      tick();
      Exit_Sens = 1'b0;
      tick();
      #2 reset = 1'b0;
      #1;
      check("rst_pay_free", free_spots, 5);
      check("rst_pay_green", Green_State, 0);
      paid_stat = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      paid_stat = 1'b0;
      tick();
      check("rst_pay_no_commit", free_spots, 5);
      check("rst_pay_no_open", Green_State, 0);

      // Exit request with an empty lot is ignored
      Exit_Sens = 1'b1;
      tick();
      tick();
      Exit_Sens = 1'b0;
      paid_stat = 1'b1;
      tick();
      paid_stat = 1'b0;
      check("empty_exit_free", free_spots, 5);
      count_gates(eh, xh);
      check("empty_exit_gate", xh, 0);

      // Reset while the entry gate is open
      Ent_Sens = 1'b1;
      tick();
      Ent_Sens = 1'b0;
      Tick_1 = 1'b1;
      tick();
      Tick_1 = 1'b0;
      check("pre_rst_gate", Ent_Gate, 1);
      check("pre_rst_free", free_spots, 4);
      #2 reset = 1'b0;
      #1;
      check("rst_open_gate", Ent_Gate, 0);
      check("rst_open_free", free_spots, 5);
      check("rst_open_sev", Sev_indicator, 5);
      tick();
      reset = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/park_lot_ctrl.md
PARK_LOT_CTRL -- requirements
Module: park_lot_ctrl

Interface
REQ-001 Parameter CAPACITY, default 5: number of spaces; legal range 1..14.
REQ-002 Parameter GATE_OPEN_CYCLES, default 4: cycles a gate stays open per vehicle; legal range 1..255.
REQ-003 Parameter TICKET_TIMEOUT, default 16: cycles allowed to take a ticket; legal range 1..255.
REQ-004 Localparam CNT_W = $clog2(CAPACITY+1): occupancy counter width.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 Ent_Sens  in  1  vehicle present at entry gate, level.
REQ-008 Exit_Sens  in  1  vehicle present at exit gate, level.
REQ-009 Tick_1  in  1  ticket taken at entry, sampled in E_TICKET only.
REQ-010 paid_stat  in  1  payment confirmed at exit, sampled in X_PAY only.
REQ-011 Ent_Gate  out  1  entry barrier open.
REQ-012 Green_State  out  1  exit barrier open.
REQ-013 Red_State  out  1  lot full indicator.
REQ-014 Sev_indicator  out  4  seven-segment digit code.
REQ-015 free_spots  out  CNT_W  free spaces, binary.
REQ-016 timeout_pulse  out  1  one-cycle pulse on ticket timeout.

Function
REQ-017 Occupancy counter occ SHALL be a registered value in 0..CAPACITY; free_spots = CAPACITY - occ.
REQ-018 Entry FSM states SHALL be E_IDLE, E_TICKET, E_FULL, E_OPEN.
REQ-019 E_IDLE: Ent_Sens=1 and free_spots>0 -> E_TICKET; Ent_Sens=1 and free_spots=0 -> E_FULL; else stay.
REQ-020 E_TICKET: Tick_1=1 -> E_OPEN, occ increments on that same edge; TICKET_TIMEOUT cycles without Tick_1 -> E_IDLE with timeout_pulse=1 for one cycle; no occ change on timeout.
REQ-021 E_FULL: stay while Ent_Sens=1; Ent_Sens=0 -> E_IDLE; never admits a vehicle.
REQ-022 E_OPEN: Ent_Gate=1 for exactly GATE_OPEN_CYCLES cycles, then E_IDLE.
REQ-023 Exit FSM states SHALL be X_IDLE, X_PAY, X_OPEN.
REQ-024 X_IDLE: Exit_Sens=1 and occ>0 -> X_PAY; Exit_Sens=1 with occ=0 SHALL be ignored.
REQ-025 X_PAY: paid_stat=1 -> X_OPEN, occ decrements on that same edge; no timeout.
REQ-026 X_OPEN: Green_State=1 for exactly GATE_OPEN_CYCLES cycles, then X_IDLE.
REQ-027 Both FSMs SHALL run concurrently and independently.
REQ-028 Simultaneous entry commit and exit commit on one edge SHALL leave occ unchanged.
REQ-029 occ SHALL never exceed CAPACITY nor go below 0; only entry decreases free_spots, so a check in E_IDLE remains valid through E_TICKET.
REQ-030 Red_State = (free_spots == 0), combinational from registered occ.
REQ-031 Sev_indicator = free_spots zero-extended to 4 bits when free_spots>0; 4'hF when free_spots=0.
REQ-032 Outputs SHALL reflect a commit on the cycle after the committing edge.

Reset
REQ-033 reset=0 SHALL immediately force E_IDLE, X_IDLE, occ=0, timers=0, Ent_Gate=0, Green_State=0, timeout_pulse=0.
REQ-034 Post-reset outputs: free_spots=CAPACITY, Red_State=0, Sev_indicator=CAPACITY.
REQ-035 Reset mid-operation (e.g. gate open, in X_PAY) SHALL abort the transaction without occ commit.

Structure
REQ-036 Package park_pkg SHALL hold the entry and exit state encodings and the Sev code 4'hF for FULL.
REQ-037 One sub-module park_gate_timer (8-bit loadable down-counter, done flag) SHALL be instantiated twice: entry (ticket timeout and gate hold) and exit (gate hold).

Verification (CAPACITY=5, GATE_OPEN_CYCLES=4, TICKET_TIMEOUT=16)
REQ-038 Reset release -> free_spots=5, Sev_indicator=5, Red_State=0, both gates closed.
REQ-039 Five entries (Ent_Sens, then Tick_1) -> free_spots 4,3,2,1,0; Sev_indicator=4'hF, Red_State=1; each Ent_Gate high exactly 4 cycles.
REQ-040 Sixth Ent_Sens while full -> E_FULL, Ent_Gate stays 0, occ stays 5; Ent_Sens=0 returns to E_IDLE.
REQ-041 Ent_Sens then no Tick_1 for 16 cycles -> timeout_pulse one cycle, E_IDLE, free_spots unchanged.
REQ-042 occ=3, Tick_1 and paid_stat commit on the same edge -> free_spots stays 2; Ent_Gate and Green_State both high 4 cycles.
REQ-043 occ=0, Exit_Sens=1 -> stays X_IDLE; reset asserted in X_PAY at occ=2 -> occ=0, Green_State=0 immediately.
